// File: rtl/speed_ramp.sv
// speed_ramp: soft-start / soft-stop setpoint generator feeding the PWM duty input.
// The registered setpoint slews toward the effective target by one LSB every
// STEP_TICKS clocks. estop forces an immediate stop to zero.
// Optional build macro SPEED_RAMP_SYNC_EN: passes target, enable and estop
// through 2-flop synchronizers, which adds two clocks to every response.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | result = 0 and effective target = 0
// S_HOLD      | result = effective target, nonzero
// S_RAMP_UP   | stepping result upward toward the effective target
// S_RAMP_DOWN | stepping result downward toward the effective target
// S_STOP      | estop asserted; result held at 0
module speed_ramp #(
    parameter int WIDTH      = 4,
    parameter int STEP_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] target,
    input  logic             enable,
    input  logic             estop,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             at_target
);

    localparam int CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RAMP_UP,
        S_RAMP_DOWN,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;

    logic [WIDTH-1:0] w_target;
    logic             w_enable;
    logic             w_estop;
    logic [WIDTH-1:0] w_tgt_eff;
    logic [WIDTH-1:0] w_result_inc;
    logic [WIDTH-1:0] w_result_dec;
    logic             w_step;

`ifdef SPEED_RAMP_SYNC_EN
    logic [WIDTH-1:0] r_target_m, r_target_s;
    logic             r_enable_m, r_enable_s;
    logic             r_estop_m,  r_estop_s;

    // Two-flop synchronizers so the inputs may come straight from switches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_target_m <= '0;
            r_target_s <= '0;
            r_enable_m <= 1'b0;
            r_enable_s <= 1'b0;
            r_estop_m  <= 1'b0;
            r_estop_s  <= 1'b0;
        end else begin
            r_target_m <= target;
            r_target_s <= r_target_m;
            r_enable_m <= enable;
            r_enable_s <= r_enable_m;
            r_estop_m  <= estop;
            r_estop_s  <= r_estop_m;
        end
    end

    assign w_target = r_target_s;
    assign w_enable = r_enable_s;
    assign w_estop  = r_estop_s;
`else
    assign w_target = target;
    assign w_enable = enable;
    assign w_estop  = estop;
`endif

    assign w_tgt_eff    = (w_enable && !w_estop) ? w_target : '0;
    assign w_result_inc = r_result + WIDTH'(1);
    assign w_result_dec = r_result - WIDTH'(1);
    assign w_step       = (r_cnt == CNT_LAST);

    // State, setpoint and tick counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Next-state logic: estop first, then target tracking, then stepping.
    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_cnt_nxt    = r_cnt;

        if (w_estop) begin
            w_state_nxt  = S_STOP;
            w_result_nxt = '0;
            w_cnt_nxt    = '0;
        end else begin
            case (r_state)
                S_STOP: begin
                    // Leave STOP for one evaluation in IDLE before any ramp.
                    w_state_nxt  = S_IDLE;
                    w_result_nxt = '0;
                    w_cnt_nxt    = '0;
                end
                S_IDLE, S_HOLD: begin
                    w_cnt_nxt = '0;
                    if (w_tgt_eff > r_result) begin
                        w_state_nxt = S_RAMP_UP;
                    end else if (w_tgt_eff < r_result) begin
                        w_state_nxt = S_RAMP_DOWN;
                    end else begin
                        w_state_nxt = (r_result == '0) ? S_IDLE : S_HOLD;
                    end
                end
                S_RAMP_UP: begin
                    if (w_tgt_eff == r_result) begin
                        w_state_nxt = (r_result == '0) ? S_IDLE : S_HOLD;
                        w_cnt_nxt   = '0;
                    end else if (w_tgt_eff < r_result) begin
                        w_state_nxt = S_RAMP_DOWN;
                        w_cnt_nxt   = '0;
                    end else if (w_step) begin
                        w_result_nxt = w_result_inc;
                        w_cnt_nxt    = '0;
                        if (w_result_inc == w_tgt_eff) begin
                            w_state_nxt = S_HOLD;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                S_RAMP_DOWN: begin
                    if (w_tgt_eff == r_result) begin
                        w_state_nxt = (r_result == '0) ? S_IDLE : S_HOLD;
                        w_cnt_nxt   = '0;
                    end else if (w_tgt_eff > r_result) begin
                        w_state_nxt = S_RAMP_UP;
                        w_cnt_nxt   = '0;
                    end else if (w_step) begin
                        w_result_nxt = w_result_dec;
                        w_cnt_nxt    = '0;
                        if (w_result_dec == w_tgt_eff) begin
                            w_state_nxt = (w_result_dec == '0) ? S_IDLE : S_HOLD;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_result_nxt = '0;
                    w_cnt_nxt    = '0;
                end
            endcase
        end
    end

    assign result    = r_result;
    assign busy      = (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);
    assign at_target = (r_result == w_tgt_eff) && !w_estop;

endmodule

// File: tb/tb_speed_ramp.sv
// Testbench for speed_ramp: directed scenarios plus random stimulus, all
// compared against a behavioural model that tracks elapsed clocks per step.
module tb_speed_ramp;

    localparam int WIDTH = 4;
    localparam int STEP  = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] target;
    logic             enable;
    logic             estop;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             at_target;

    int n_checks = 0;
    int n_errors = 0;

    speed_ramp #(.WIDTH(WIDTH), .STEP_TICKS(STEP)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .target    (target),
        .enable    (enable),
        .estop     (estop),
        .result    (result),
        .busy      (busy),
        .at_target (at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: speed value, whether a ramp is in progress, its
    // direction and how many clocks have elapsed toward the next step.
    int m_result;
    int m_ramp;
    int m_dir;
    int m_elapsed;
    int m_stopped;

    always @(posedge clk or negedge rst) begin
        int r, rp, d, el, st, tgt;
        if (!rst) begin
            m_result  <= 0;
            m_ramp    <= 0;
            m_dir     <= 0;
            m_elapsed <= 0;
            m_stopped <= 0;
        end else begin
            r = m_result; rp = m_ramp; d = m_dir; el = m_elapsed; st = m_stopped;
            tgt = (enable && !estop) ? int'(target) : 0;
            if (estop) begin
                r = 0; rp = 0; el = 0; st = 1;
            end else if (st != 0) begin
                st = 0;
            end else if (rp == 0) begin
                if (tgt != r) begin
                    rp = 1; el = 0; d = (tgt > r) ? 1 : -1;
                end
            end else if (tgt == r) begin
                rp = 0; el = 0;
            end else if (((tgt > r) ? 1 : -1) != d) begin
                d = -d; el = 0;
            end else begin
                el = el + 1;
                if (el == STEP) begin
                    r = r + d; el = 0;
                    if (r == tgt) rp = 0;
                end
            end
            m_result  <= r;
            m_ramp    <= rp;
            m_dir     <= d;
            m_elapsed <= el;
            m_stopped <= st;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int tgt;
        tgt = (enable && !estop) ? int'(target) : 0;
        chk({tag, "_result"}, int'(result), m_result);
        chk({tag, "_busy"}, int'(busy), m_ramp);
        chk({tag, "_at_target"}, int'(at_target), ((m_result == tgt) && !estop) ? 1 : 0);
    endtask

    // Advance n rising edges; sample 1 time unit after each edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_model("model");
        end
    endtask

    task automatic ramp_until(input int val, input string tag);
        int found;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            cyc(1);
            if (int'(result) == val) found = 1;
        end
        chk(tag, found, 1);
    endtask

    initial begin
        int max_res;
        rst = 1'b0; target = '0; enable = 1'b0; estop = 1'b0;
        cyc(3);
        chk("reset_result", int'(result), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_at_target", int'(at_target), 1);
        rst = 1'b1;
        cyc(2);

        // Ramp 0 -> 5 from IDLE
        enable = 1'b1; target = 4'd5;
        cyc(1);
        chk("up5_busy_start", int'(busy), 1);
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (i % 4 == 0) chk("up5_step", int'(result), i / 4);
            if (i == 19) chk("up5_before", int'(result), 4);
        end
        chk("up5_busy_end", int'(busy), 0);
        chk("up5_at_target", int'(at_target), 1);

        // HOLD at 5 -> 2
        target = 4'd2;
        cyc(1);
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            if (i % 4 == 0) chk("down2_step", int'(result), 5 - i / 4);
        end
        chk("down2_busy_end", int'(busy), 0);

        // Reverse mid-ramp at 3
        target = 4'd0;
        cyc(10);
        target = 4'd15;
        ramp_until(3, "rev_reach3");
        target = 4'd1;
        max_res = 0;
        cyc(1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            if (int'(result) > max_res) max_res = int'(result);
            if (i == 3) chk("rev_hold3", int'(result), 3);
            if (i == 4) chk("rev_step2", int'(result), 2);
            if (i == 8) chk("rev_step1", int'(result), 1);
        end
        chk("rev_no_overshoot", (max_res <= 3) ? 1 : 0, 1);

        // estop while ramping at 6
        target = 4'd15;
        ramp_until(6, "estop_reach6");
        estop = 1'b1;
        cyc(1);
        chk("estop_result", int'(result), 0);
        chk("estop_busy", int'(busy), 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("estop_held", int'(result), 0);
        end
        estop = 1'b0; target = 4'd3;
        cyc(1);
        chk("estop_exit_idle", int'(busy), 0);
        cyc(1);
        chk("estop_restart_busy", int'(busy), 1);
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            if (i % 4 == 0) chk("estop_restart_step", int'(result), i / 4);
        end

        // enable drop from HOLD at 7
        target = 4'd7;
        ramp_until(7, "en_reach7");
        cyc(2);
        enable = 1'b0;
        cyc(1);
        for (int i = 1; i <= 28; i++) begin
            cyc(1);
            if (i == 27) chk("en_down_before", int'(result), 1);
        end
        chk("en_down_result", int'(result), 0);
        chk("en_down_busy", int'(busy), 0);
        chk("en_down_at_target", int'(at_target), 1);

        // Asynchronous reset mid-ramp, then 0 -> 9 in 36 edges
        enable = 1'b1; target = 4'd9;
        cyc(10);
        #2 rst = 1'b0;
        #1;
        chk("arst_result", int'(result), 0);
        chk("arst_busy", int'(busy), 0);
        check_model("arst");
        @(posedge clk);
        #1 rst = 1'b1;
        cyc(1);
        for (int i = 1; i <= 36; i++) begin
            cyc(1);
            if (i == 35) chk("rst9_before", int'(result), 8);
        end
        chk("rst9_result", int'(result), 9);

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 8 == 0) target = WIDTH'($urandom % 16);
            if ($urandom % 40 == 0) enable = ~enable;
            if ($urandom % 60 == 0) estop = 1'b1;
            else if (estop && ($urandom % 3 == 0)) estop = 1'b0;
            if ($urandom % 400 == 0) begin
                #2 rst = 1'b0;
                #1 check_model("rand_arst");
                @(posedge clk);
                #1 rst = 1'b1;
            end
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
